muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine in the EX stage, alongside the single-cycle ALU.
- Executes the `ALUCTRL_MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM` and `REMU` codes from alu_control_def.v.
- Drives MulDivAluReady back to the control unit. The control unit stalls the pipeline while ready is low and enables RegWrite when it is high.
- Shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// ============================================================================
// muldiv_if : EX-stage request/response bundle for the RV32M mul/div engine
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
  parameter int BITS = 32
);
  logic            valid;
  logic [4:0]      ALUCtrl;
  logic [BITS-1:0] operand_a;
  logic [BITS-1:0] operand_b;
  logic            pipe_stall;
  logic [BITS-1:0] result;
  logic            MulDivAluReady;

  modport master (
    output valid, ALUCtrl, operand_a, operand_b, pipe_stall,
    input  result, MulDivAluReady
  );

  modport slave (
    input  valid, ALUCtrl, operand_a, operand_b, pipe_stall,
    output result, MulDivAluReady
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M engine, shift-add multiply / restoring divide
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int BITS = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  md
);

  localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
  localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
  localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
  localparam logic [4:0] ALUCTRL_REM    = 5'h16;
  localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

  localparam int            CW       = (BITS > 2) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [4:0]          op_q;
  logic                sa_q;
  logic                sb_q;
  logic [CW-1:0]       cnt_q;
  logic [2*BITS-1:0]   acc_q;
  logic [BITS-1:0]     bmag_q;
  logic [BITS-1:0]     result_q;
  logic                ready_q;

  // Input-side decode, used only when accepting from IDLE
  logic            in_is_mul, in_is_div, is_md;
  logic            in_signed_a, in_signed_b;
  logic            in_sa, in_sb;
  logic [BITS-1:0] in_mag_a, in_mag_b;
  logic            in_b_zero, in_ovf, in_special;
  logic [BITS-1:0] in_special_res;

  always_comb begin
    in_is_mul   = (md.ALUCtrl == ALUCTRL_MUL)   || (md.ALUCtrl == ALUCTRL_MULH) ||
                  (md.ALUCtrl == ALUCTRL_MULHSU) || (md.ALUCtrl == ALUCTRL_MULHU);
    in_is_div   = (md.ALUCtrl == ALUCTRL_DIV)   || (md.ALUCtrl == ALUCTRL_DIVU) ||
                  (md.ALUCtrl == ALUCTRL_REM)   || (md.ALUCtrl == ALUCTRL_REMU);
    is_md       = md.valid && (in_is_mul || in_is_div);
    in_signed_b = (md.ALUCtrl == ALUCTRL_MUL) || (md.ALUCtrl == ALUCTRL_MULH) ||
                  (md.ALUCtrl == ALUCTRL_DIV) || (md.ALUCtrl == ALUCTRL_REM);
    in_signed_a = in_signed_b || (md.ALUCtrl == ALUCTRL_MULHSU);
    in_sa       = in_signed_a && md.operand_a[BITS-1];
    in_sb       = in_signed_b && md.operand_b[BITS-1];
    in_mag_a    = in_sa ? (~md.operand_a + 1'b1) : md.operand_a;
    in_mag_b    = in_sb ? (~md.operand_b + 1'b1) : md.operand_b;
    in_b_zero   = (md.operand_b == '0);
    in_ovf      = ((md.ALUCtrl == ALUCTRL_DIV) || (md.ALUCtrl == ALUCTRL_REM)) &&
                  (md.operand_a == {1'b1, {(BITS-1){1'b0}}}) && (md.operand_b == '1);
    in_special  = in_is_div && (in_b_zero || in_ovf);
    if (in_b_zero) begin
      in_special_res = ((md.ALUCtrl == ALUCTRL_DIV) || (md.ALUCtrl == ALUCTRL_DIVU)) ?
                       '1 : md.operand_a;
    end else begin
      in_special_res = (md.ALUCtrl == ALUCTRL_DIV) ? md.operand_a : '0;
    end
  end

  // One iteration of either algorithm; acc holds {hi/rem, lo/quotient}
  logic              op_is_div;
  logic [BITS:0]     mul_sum;
  logic [2*BITS-1:0] mul_next;
  logic [BITS:0]     div_shift;
  logic [BITS+1:0]   div_diff;
  logic              div_ge;
  logic [BITS-1:0]   div_rem;
  logic [2*BITS-1:0] div_next;
  logic [2*BITS-1:0] acc_d;

  always_comb begin
    op_is_div = (op_q == ALUCTRL_DIV) || (op_q == ALUCTRL_DIVU) ||
                (op_q == ALUCTRL_REM) || (op_q == ALUCTRL_REMU);
    mul_sum   = {1'b0, acc_q[2*BITS-1:BITS]} + {1'b0, (acc_q[0] ? bmag_q : {BITS{1'b0}})};
    mul_next  = {mul_sum, acc_q[BITS-1:1]};
    div_shift = {acc_q[2*BITS-1:BITS], acc_q[BITS-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, bmag_q};
    div_ge    = ~div_diff[BITS+1];
    div_rem   = div_ge ? div_diff[BITS-1:0] : div_shift[BITS-1:0];
    div_next  = {div_rem, acc_q[BITS-2:0], div_ge};
    acc_d     = op_is_div ? div_next : mul_next;
  end

  logic [2*BITS-1:0] prod_s;
  logic [BITS-1:0]   quo_s, rem_s, final_d;

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? (~acc_d + 1'b1) : acc_d;
    quo_s  = (sa_q ^ sb_q) ? (~acc_d[BITS-1:0] + 1'b1) : acc_d[BITS-1:0];
    rem_s  = sa_q ? (~acc_d[2*BITS-1:BITS] + 1'b1) : acc_d[2*BITS-1:BITS];
    case (op_q)
      ALUCTRL_MUL:                          final_d = prod_s[BITS-1:0];
      ALUCTRL_MULH, ALUCTRL_MULHSU,
      ALUCTRL_MULHU:                        final_d = prod_s[2*BITS-1:BITS];
      ALUCTRL_DIV, ALUCTRL_DIVU:            final_d = quo_s;
      default:                              final_d = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      bmag_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_md) begin
            op_q <= md.ALUCtrl;
            if (in_special) begin
              result_q <= in_special_res;
              ready_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              sa_q    <= in_sa;
              sb_q    <= in_sb;
              acc_q   <= {{BITS{1'b0}}, in_mag_a};
              bmag_q  <= in_mag_b;
              cnt_q   <= '0;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!md.valid) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            if (cnt_q == LAST_CNT) begin
              result_q <= final_d;
              ready_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Held result survives a stall; leaving never re-accepts the same op
          if (!md.valid || !md.pipe_stall) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign md.result         = result_q;
  assign md.MulDivAluReady = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed + random check of muldiv_unit against an arithmetic model
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] last_exp;

  muldiv_if #(.BITS(32)) bus ();

  muldiv_unit #(.BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa64, sb64;
    longint unsigned ua64, ub64;
    logic [63:0]     p;
    int              si_a, si_b, q;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    si_a = a;
    si_b = b;
    case (op)
      OP_MUL:    begin p = sa64 * sb64;          return p[31:0];  end
      OP_MULH:   begin p = sa64 * sb64;          return p[63:32]; end
      OP_MULHSU: begin p = sa64 * longint'(ub64); return p[63:32]; end
      OP_MULHU:  begin p = ua64 * ub64;          return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = si_a / si_b;
        return q;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = si_a % si_b;
        return q;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div;
    is_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    return is_div && ((b == 0) ||
           ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op (caller sits just after a rising edge), wait for ready, release
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int hold);
    logic [31:0] exp;
    int          exp_lat;
    int          n;
    bit          seen;
    exp     = model(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    bus.ALUCtrl    = op;
    bus.operand_a  = a;
    bus.operand_b  = b;
    bus.valid      = 1'b1;
    bus.pipe_stall = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = bus.MulDivAluReady;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, bus.result, exp);
    if (hold > 0) begin
      bus.pipe_stall = 1'b1;
      bus.operand_a  = ~a;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_ready"}, {31'b0, bus.MulDivAluReady}, 32'd1);
        check({tag, "_hold_result"}, bus.result, exp);
      end
      bus.pipe_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, "_ready_drop"}, {31'b0, bus.MulDivAluReady}, 32'd0);
    bus.valid = 1'b0;
    last_exp  = exp;
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bit          flush_seen;
    total = 0;
    bad   = 0;
    last_exp       = '0;
    rst            = 1'b1;
    bus.valid      = 1'b0;
    bus.ALUCtrl    = '0;
    bus.operand_a  = '0;
    bus.operand_b  = '0;
    bus.pipe_stall = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'b0, bus.MulDivAluReady}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, "mul_7x-3", 0);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff", 0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff", 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, "mulhsu", 0);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, "div_-7_2", 0);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, "rem_-7_2", 0);
    run_op(OP_DIVU,   32'd100,       32'd7,         "divu_100_7", 0);
    run_op(OP_REMU,   32'd100,       32'd7,         "remu_100_7", 0);

    // Flush at BUSY iteration 10: valid drops, ready must never appear
    bus.ALUCtrl   = OP_DIVU;
    bus.operand_a = 32'd1000;
    bus.operand_b = 32'd3;
    bus.valid     = 1'b1;
    repeat (11) @(posedge clk);
    #1 bus.valid = 1'b0;
    flush_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.MulDivAluReady) flush_seen = 1'b1;
    end
    check("flush_no_ready", {31'b0, flush_seen}, 32'd0);
    check("flush_result_kept", bus.result, last_exp);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply
    bus.ALUCtrl   = OP_MUL;
    bus.operand_a = 32'd1234;
    bus.operand_b = 32'd5678;
    bus.valid     = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_result", bus.result, last_exp);
    rst = 1'b1;
    #1;
    check("async_rst_ready", {31'b0, bus.MulDivAluReady}, 32'd0);
    check("async_rst_result", bus.result, 32'd0);
    bus.valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_op(OP_MUL, 32'd3, 32'd4, "mul_3x4_after_rst", 0);

    run_op(OP_DIVU, 32'd5,         32'd0,         "divu_by0", 0);
    run_op(OP_REM,  32'd5,         32'd0,         "rem_by0", 0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);

    run_op(OP_MULH,  32'h1234_5678, 32'h9ABC_DEF0, "mulh_hold", 5);
    run_op(OP_DIVU,  32'hDEAD_BEEF, 32'h0000_1234, "b2b_divu", 0);
    run_op(OP_MULHU, 32'hCAFE_F00D, 32'h8765_4321, "b2b_mulhu", 0);

    for (int i = 0; i < 40; i++) begin
      rop = 5'h10 + 5'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = ~32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0h", i, rop), (i % 9 == 4) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
